// File: rtl/lzc_pkg.sv
// Shared widths and result type for the 8-bit leading-zero counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lzc_pkg;

    localparam int LZC_W  = 8;
    localparam int LZC_ZW = 3;

    // Count result: v=0 means operand was zero and z is forced to 0
    typedef struct packed {
        logic              v;
        logic [LZC_ZW-1:0] z;
    } lzc_res_t;

endpackage

// File: rtl/lzc_miao_merge.sv
// Two-input merge node: combines high/low group counts of K bits into K+1 bits.
// Latency: combinational.
// Backpressure: none.
module lzc_miao_merge #(
    parameter int K = 1
) (
    input  logic         vH,
    input  logic [K-1:0] zH,
    input  logic         vL,
    input  logic [K-1:0] zL,
    output logic         v,
    output logic [K:0]   z
);

    // MSB set when the whole high group is zero; then the low group's count
    // supplies the remaining bits, otherwise the high group's count does.
    assign v = vH | vL;
    assign z = {~vH, (vH ? zH : zL)};

endmodule

// File: rtl/lzc_miao_8.sv
// 8-bit leading-zero counter built as a Miao tree of merge nodes, optional output register.
// Latency: 1 cycle with REG_OUT=1, combinational with REG_OUT=0.
// Backpressure: none; accepts a new operand every cycle.
module lzc_miao_8
    import lzc_pkg::*;
#(
    parameter int REG_OUT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LZC_W-1:0]  in,
    output logic [LZC_ZW-1:0] out_z,
    output logic              v
);

    // Level 0: 2-bit leaves, index 3 is bits [7:6]
    logic [3:0] leaf_v;
    logic [3:0] leaf_z;

    for (genvar p = 0; p < 4; p++) begin : g_leaf
        assign leaf_v[p] = in[2*p+1] | in[2*p];
        assign leaf_z[p] = ~in[2*p+1];
    end

    // Level 1: 4-bit groups
    logic       hi_v;
    logic [1:0] hi_z;
    logic       lo_v;
    logic [1:0] lo_z;

    lzc_miao_merge #(.K(1)) u_merge_hi (
        .vH (leaf_v[3]),
        .zH (leaf_z[3:3]),
        .vL (leaf_v[2]),
        .zL (leaf_z[2:2]),
        .v  (hi_v),
        .z  (hi_z)
    );

    lzc_miao_merge #(.K(1)) u_merge_lo (
        .vH (leaf_v[1]),
        .zH (leaf_z[1:1]),
        .vL (leaf_v[0]),
        .zL (leaf_z[0:0]),
        .v  (lo_v),
        .z  (lo_z)
    );

    // Level 2: full 8-bit result
    logic              root_v;
    logic [LZC_ZW-1:0] root_z;

    lzc_miao_merge #(.K(2)) u_merge_root (
        .vH (hi_v),
        .zH (hi_z),
        .vL (lo_v),
        .zL (lo_z),
        .v  (root_v),
        .z  (root_z)
    );

    // A zero operand would naturally count 7; force the defined value 0 instead
    lzc_res_t res;
    assign res.v = root_v;
    assign res.z = root_v ? root_z : '0;

    if (REG_OUT != 0) begin : g_reg
        lzc_res_t res_q;

        // Capture the result each edge; reset clears it immediately
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_q <= '0;
            end else begin
                res_q <= res;
            end
        end

        assign out_z = res_q.z;
        assign v     = res_q.v;
    end else begin : g_comb
        // Clock and reset have no role in the combinational build
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign out_z = res.z;
        assign v     = res.v;
    end

endmodule

// File: tb/tb_lzc_miao_8.sv
// Bench for lzc_miao_8: registered and combinational builds side by side.
// Latency: checks exact 1-cycle latency of the registered build.
// Backpressure: none.
module tb_lzc_miao_8;
    import lzc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_d = 8'hFF;
    logic [2:0] z_r;
    logic       v_r;
    logic [2:0] z_c;
    logic       v_c;

    int passed = 0;
    int total  = 0;

    // Expected registered output {v, z}
    logic [3:0] exp_reg = 4'h0;

    always #5 clk = ~clk;

    lzc_miao_8 #(.REG_OUT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_d),
        .out_z (z_r),
        .v     (v_r)
    );

    lzc_miao_8 #(.REG_OUT(0)) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_d),
        .out_z (z_c),
        .v     (v_c)
    );

    // Reference: scan from the MSB down for the first one
    function automatic logic [3:0] ref_model(input logic [7:0] x);
        for (int i = 7; i >= 0; i--) begin
            if (x[i]) return {1'b1, 3'(7 - i)};
        end
        return 4'h0;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s in=%02h: got v=%0b z=%0d, want v=%0b z=%0d",
                     name, in_d, act[3], act[2:0], exp[3], exp[2:0]);
        end
    endtask

    // Called at posedge+1: apply x, check comb now, check reg holds old value
    // until the edge, then check reg one edge later.
    task automatic drive(input logic [7:0] x, input logic [3:0] exp);
        in_d = x;
        #1;
        check("comb", {v_c, z_c}, exp);
        check("reg_hold", {v_r, z_r}, exp_reg);
        @(posedge clk);
        #1;
        exp_reg = exp;
        check("reg", {v_r, z_r}, exp_reg);
    endtask

    typedef struct {
        logic [7:0] in;
        logic [2:0] z;
        logic       v;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{8'h01, 3'd7, 1'b1};
        tbl[1]  = '{8'h02, 3'd6, 1'b1};
        tbl[2]  = '{8'h04, 3'd5, 1'b1};
        tbl[3]  = '{8'h08, 3'd4, 1'b1};
        tbl[4]  = '{8'h10, 3'd3, 1'b1};
        tbl[5]  = '{8'h20, 3'd2, 1'b1};
        tbl[6]  = '{8'h40, 3'd1, 1'b1};
        tbl[7]  = '{8'h80, 3'd0, 1'b1};
        tbl[8]  = '{8'hFF, 3'd0, 1'b1};
        tbl[9]  = '{8'h3F, 3'd2, 1'b1};
        tbl[10] = '{8'h0B, 3'd4, 1'b1};
        tbl[11] = '{8'h01, 3'd7, 1'b1};
        tbl[12] = '{8'h01, 3'd7, 1'b1};
        tbl[13] = '{8'h00, 3'd0, 1'b0};
        tbl[14] = '{8'h55, 3'd1, 1'b1};
        tbl[15] = '{8'h00, 3'd0, 1'b0};

        // Reset held with all-ones operand
        #1;
        check("rst_async", {v_r, z_r}, 4'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold", {v_r, z_r}, 4'h0);
            check("rst_comb", {v_c, z_c}, 4'b1000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_reg = 4'b1000;
        check("rst_release", {v_r, z_r}, exp_reg);

        // Directed vectors, back to back
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].in, {tbl[i].v, tbl[i].z});
        end

        // Exhaustive sweep
        for (int i = 0; i < 256; i++) begin
            drive(8'(i), ref_model(8'(i)));
        end

        // Random stream
        for (int i = 0; i < 200; i++) begin
            logic [7:0] r;
            r = 8'($urandom_range(255));
            drive(r, ref_model(r));
        end

        // Async reset mid-stream
        drive(8'h10, 4'b1011);
        @(negedge clk);
        in_d = 8'h03;
        rst_n = 1'b0;
        #1;
        check("mid_rst_async", {v_r, z_r}, 4'h0);
        check("mid_rst_comb", {v_c, z_c}, 4'b1110);
        @(posedge clk);
        #1;
        check("mid_rst_edge", {v_r, z_r}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_reg = 4'h0;
        #1;
        check("mid_rst_release_hold", {v_r, z_r}, 4'h0);
        @(posedge clk);
        #1;
        exp_reg = 4'b1110;
        check("mid_rst_first_capture", {v_r, z_r}, exp_reg);
        drive(8'h80, 4'b1000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lzc_miao_8.md
Name: lzc_miao_8

Overview:
- 8-bit leading-zero counter built as a Miao-style tree of two-input merge nodes.
- Reports the number of leading zeros of an 8-bit operand and a valid flag (operand non-zero).
- Used in the FP multiplier normalisation path to compute mantissa shift amounts.
- Combinational counting core followed by an optional output register stage.

Parameters:
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs combinational, clk/rst_n unused.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- in  input  8  operand; bit 7 is MSB, counting starts at bit 7
- out_z  output  3  number of leading zeros, 0..7; valid only when v=1
- v  output  1  1 when in != 0

Interface (already decided):
- One clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Function: out_z = index distance from bit 7 to the highest set bit of in.
  - Examples: in=8'b1xxxxxxx -> 0; 8'b01xxxxxx -> 1; 8'b00000001 -> 7.
  - Lower bits below the leading one are don't-care.
- v = |in.
- in = 8'h00: v=0 and out_z forced to 3'd0 (defined value, not X).
- Core structure (log2 levels):
  - Level 0: four 2-bit pairs, each gives valid = a|b and z = ~a (1 bit).
  - Level 1: merge adjacent pairs into 4-bit groups.
  - Level 2: merge into the 8-bit result.
- Merge rule for high group (vH, zH) and low group (vL, zL) of k-bit count each:
  - v = vH | vL.
  - z = {~vH, vH ? zH : zL} (k+1 bits).
- REG_OUT=1:
  - out_z and v sampled on the rising edge of clk.
  - Latency exactly 1 cycle; new operand every cycle (throughput 1/cycle).
  - No handshake.
- REG_OUT=0: outputs follow in combinationally, zero latency.
- Reset (REG_OUT=1): rst_n low immediately forces out_z=0 and v=0, independent of clk.
  - First capture occurs on the first rising edge after rst_n deasserts.
  - Reset asserted mid-stream discards the in-flight result.
- No X propagation: all 256 inputs produce fully defined outputs.

Decomposition:
- Shared package lzc_pkg:
  - LZC_W = 8 (operand width).
  - LZC_ZW = 3 (count width, clog2 of LZC_W).
- One sub-module: lzc_miao_merge, parameterised on input count width K.
  - Inputs vH, zH[K-1:0], vL, zL[K-1:0].
  - Outputs v, z[K:0].
  - Instantiated 2x at K=1 and 1x at K=2.
- The 2-bit leaf logic is inline in lzc_miao_8.

Test Plan:
- Reset: hold rst_n=0 with in=8'hFF for 3 cycles -> out_z=0, v=0 throughout.
  - Release rst_n; one edge later -> out_z=0, v=1.
- Zero operand: in=8'h00 -> after 1 cycle, v=0 and out_z=0.
- Walking one: in = 8'h01, 02, 04, 08, 10, 20, 40, 80 on consecutive cycles.
  - Expected out_z = 7, 6, 5, 4, 3, 2, 1, 0, each one cycle later, v=1.
- Don't-care lower bits:
  - 8'hFF -> 0.
  - 8'h3F -> 2.
  - 8'h0B -> 4.
  - 8'h01 -> 7 (already in the walking sequence; repeat back-to-back to confirm no state carryover).
- Exhaustive: all 256 inputs, back-to-back.
  - Compare against a reference model (count from MSB, 0 and v=0 for zero).
  - Check 1-cycle latency for every value.
- Async reset mid-stream: assert rst_n between clock edges while v=1 -> outputs clear immediately, not at the next edge.
  - Run the same checks with REG_OUT=0: outputs match the model within the same timestep.
